// File: rtl/newcell_mem_subsys.sv
// Unified single-port memory for the Newcell CPU: instruction fetch and load/store share one
// word array through a round-robin arbiter, with req/ack handshakes and WAIT extra cycles per access.
module newcell_mem_subsys #(
  parameter int DEPTH = 1024,
  parameter int WAIT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic        d_sign_ext,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WAIT_L = 3'(WAIT);

  // Handshake: a requester holds req and its fields until the one-cycle ack; ack marks completion.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t       r_state;
  logic [2:0]   r_cnt;
  logic         r_last_d;
  logic         r_gnt_d;
  logic         r_we;
  logic         r_sign;
  logic [1:0]   r_size;
  logic [AW+1:0] r_addr;
  logic [31:0]  r_wdata;
  logic [31:0]  r_mem [DEPTH];

  logic          w_any, w_gnt_d, w_commit, w_err, w_mem_we;
  logic          w_a_d, w_a_we, w_a_sign;
  logic [1:0]    w_a_size;
  logic [AW+1:0] w_a_addr;
  logic [31:0]   w_a_wdata, w_word, w_load, w_wlane;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [3:0]    w_wmask;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  assign w_unused = ^{i_addr[31:AW+2], d_addr[31:AW+2]};

  // Ties go to whichever port did not win last time.
  assign w_any   = i_req | d_req;
  assign w_gnt_d = d_req & (~i_req | ~r_last_d);

  // While idle the winner's fields feed the datapath directly so WAIT=0 commits on the accept edge.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_a_d     = w_gnt_d;
      w_a_we    = w_gnt_d & d_we;
      w_a_size  = w_gnt_d ? d_size : 2'b10;
      w_a_sign  = w_gnt_d & d_sign_ext;
      w_a_addr  = w_gnt_d ? d_addr[AW+1:0] : i_addr[AW+1:0];
      w_a_wdata = d_wdata;
    end else begin
      w_a_d     = r_gnt_d;
      w_a_we    = r_we;
      w_a_size  = r_size;
      w_a_sign  = r_sign;
      w_a_addr  = r_addr;
      w_a_wdata = r_wdata;
    end
  end

  assign w_commit = rst & (((r_state == S_IDLE) & w_any & (WAIT_L == 3'd0)) |
                           ((r_state == S_WAIT) & (r_cnt == 3'd1)));

  assign w_idx  = w_a_addr[AW+1:2];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_a_addr[1:0], 3'b000} +: 8];
  assign w_half = w_a_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_err  = w_a_d & ((w_a_size == 2'b11) |
                           ((w_a_size == 2'b01) & w_a_addr[0]) |
                           ((w_a_size == 2'b10) & (w_a_addr[1:0] != 2'b00)));

  always_comb begin
    w_load  = w_word;
    w_wmask = 4'b0000;
    w_wlane = w_a_wdata;
    case (w_a_size)
      2'b00: begin
        w_load  = {{24{w_a_sign & w_byte[7]}}, w_byte};
        w_wmask = 4'b0001 << w_a_addr[1:0];
        w_wlane = {4{w_a_wdata[7:0]}};
      end
      2'b01: begin
        w_load  = {{16{w_a_sign & w_half[15]}}, w_half};
        w_wmask = w_a_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_a_wdata[15:0]}};
      end
      2'b10: begin
        w_load  = w_word;
        w_wmask = 4'b1111;
        w_wlane = w_a_wdata;
      end
      default: begin
        w_load  = 32'h0;
        w_wmask = 4'b0000;
        w_wlane = w_a_wdata;
      end
    endcase
    if (w_err) w_load = 32'h0;
  end

  assign w_mem_we = w_commit & w_a_we & ~w_err;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_mem_we && w_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_last_d <= 1'b0;
      r_gnt_d  <= 1'b0;
      r_we     <= 1'b0;
      r_sign   <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      i_ack    <= 1'b0;
      i_rdata  <= 32'h0;
      d_ack    <= 1'b0;
      d_rdata  <= 32'h0;
      d_err    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (w_commit) begin
        if (w_a_d) begin
          d_ack   <= 1'b1;
          d_rdata <= w_a_we ? 32'h0 : w_load;
          d_err   <= w_err;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= w_word;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt_d  <= w_a_d;
            r_we     <= w_a_we;
            r_sign   <= w_a_sign;
            r_size   <= w_a_size;
            r_addr   <= w_a_addr;
            r_wdata  <= w_a_wdata;
            r_last_d <= w_gnt_d;
            r_cnt    <= WAIT_L;
            busy     <= 1'b1;
            r_state  <= (WAIT_L == 3'd0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) r_state <= S_ACK;
        end
        S_ACK: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/newcell_mem_subsys.md
# newcell_mem_subsys

Parametrised unified memory subsystem for the Newcell CPU, replacing the separate combinational instruction memory and data memory with one single-port word array. The instruction-fetch port and the load/store port share the array through a round-robin arbiter. Accesses use a req/ack handshake with a configurable number of wait states. Byte, half-word and word accesses are supported, with sign or zero extension and misalignment detection.

## Interface
- DEPTH, 1024: array depth in 32-bit words; power of two, ≥ 4.
- WAIT, 1: extra access cycles, 0..7.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-fetch request.
- i_addr  in  32  fetch byte address; bits [1:0] ignored.
- i_ack  out  1  one-cycle fetch completion strobe.
- i_rdata  out  32  fetched word; valid while i_ack=1.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- d_sign_ext  in  1  1 = sign-extend load, 0 = zero-extend load.
- d_wdata  in  32  store data, right-aligned.
- d_ack  out  1  one-cycle data completion strobe.
- d_rdata  out  32  load result; valid while d_ack=1.
- d_err  out  1  misaligned or illegal size; valid while d_ack=1.
- busy  out  1  1 whenever the FSM is not IDLE.

## Operation
- **Address decode:** word index = addr[$clog2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH bytes.
- **FSM states:**
  - IDLE: if any request is high, grant one requester, latch all of its request fields, and load the wait counter with WAIT. Go to ACK if WAIT=0, otherwise to WAIT_ST.
  - WAIT_ST: decrement the counter each cycle. Go to ACK on the edge where the counter reaches 0.
  - ACK: assert the granted port's ack for exactly one cycle, then return to IDLE.
- **Arbitration:**
  - The last_grant bit resets to INSTR.
  - On a tie, the port not in last_grant wins, so the first tie after reset goes to data.
  - A lone request always wins.
  - last_grant updates on every grant.
- **Commit point:** the array read or write happens on the edge entering ACK. Read data is registered.
- **Byte lanes:** little-endian. A store writes only the addressed lanes:
  - byte: lane addr[1:0] ← wdata[7:0]
  - half: lanes addr[1]*2 and +1 ← wdata[15:0]
  - word: all four lanes.
- **Loads:** return the selected byte or half in bits [7:0] or [15:0]. The upper bits are filled with the lane's MSB if d_sign_ext=1, otherwise with 0.
- **Errors:** d_err=1 for a half access with addr[0]=1, a word access with addr[1:0]≠0, or d_size=11. On an error:
  - the array is not written
  - d_rdata=0
  - the timing is identical to a normal access.
- **Instruction port:** read-only and never errors.
- **Requester contract:** hold req and all request fields stable until ack. Drop req in the ack cycle, or keep it high to request again; it is then treated as a new request in the next IDLE.

## Timing
- **Reset values:** all outputs 0, FSM=IDLE, counter=0, last_grant=INSTR. Array contents are not reset.
- **Latency:** ack is asserted WAIT+1 cycles after the acceptance cycle (IDLE with req=1).
- **Throughput:** one access per WAIT+2 cycles.
- **busy:** high from the cycle after acceptance through the ACK cycle inclusive.
- **Non-granted request:** waits and is served in the next IDLE. At most one access is outstanding.
- **i_rdata / d_rdata:** hold their last value outside ack. The checker samples them only with ack.
- **Reset mid-access:** the FSM returns to IDLE immediately.
  - If reset asserts before the commit edge, the pending store is not written and no ack is issued.
  - Stores already committed remain.
- **req drop before ack:** a protocol violation. The access still completes and acks.

## Test plan
- WAIT=1: store word 0xDEADBEEF to 0x10, then load word 0x10 → d_ack in the 2nd cycle after each acceptance; d_rdata=0xDEADBEEF; d_err=0.
- Store byte 0x80 to 0x13, then load byte 0x13 with sign_ext=1 → 0xFFFFFF80. With sign_ext=0 → 0x00000080. Lanes 0x10..0x12 are unchanged (0xADBEEF).
- Load half at 0x11 and store word at 0x12 → d_err=1, d_rdata=0, and memory at 0x10 is unchanged. d_size=11 → d_err=1.
- i_req and d_req held high together from reset → grants alternate data, instr, data, instr; each ack arrives WAIT+1 cycles after its acceptance.
- DEPTH=1024: store to 0x1000_0004, then fetch at 0x4 → i_rdata equals the stored word (wrap-around).
- WAIT=3: deassert rst two cycles into a store → no d_ack, busy=0 and all outputs 0 during reset. A subsequent load returns the old value.
